// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and elaboration helpers for the true dual-port block RAM
//
// Purpose: holds the same-port write-mode enum, the clear/ready state enum and the
// helper that validates the byte-lane split of the data word.
// Ports: none (package).

package bram_pkg;

    typedef enum logic [1:0] {
        WM_READ_FIRST  = 2'd0,
        WM_WRITE_FIRST = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } write_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } states_e;

    // A word must split into a whole number of non-empty byte lanes.
    function automatic bit byte_merge_ok(input int data_w, input int byte_w);
        return (byte_w > 0) && (data_w >= byte_w) && ((data_w % byte_w) == 0);
    endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// rtl/bram_port_pipe.sv - per-port output register, optional second stage and valid pipeline
//
// Purpose: registers the read result of one RAM port. Data is only loaded on an
// access that produces a result, so the output holds otherwise; valid travels
// alongside the data through the same number of stages.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   i_valid         this edge carries an access result
//   i_data          result word for this edge
//   o_data          registered result word (1 or 2 stages)
//   o_valid         registered valid strobe matching o_data

module bram_port_pipe #(
    parameter int DataWidth   = 16,
    parameter int ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 i_valid,
    input  logic [DataWidth-1:0] i_data,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_valid
);

    logic [DataWidth-1:0] r_data1;
    logic                 r_valid1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_data1  <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= i_valid;
            if (i_valid) begin
                r_data1 <= i_data;
            end
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic [DataWidth-1:0] r_data2;
        logic                 r_valid2;

        // The second stage only reloads behind a real result so it holds too.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_data2  <= '0;
                r_valid2 <= 1'b0;
            end else begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_data2 <= r_data1;
                end
            end
        end

        assign o_data  = r_data2;
        assign o_valid = r_valid2;
    end else begin : g_lat1
        assign o_data  = r_data1;
        assign o_valid = r_valid1;
    end

endmodule

// File: rtl/bram_tdp.sv
// rtl/bram_tdp.sv - single-clock true dual-port block RAM with byte enables and clear sweep
//
// Purpose: Depth = 2**AddrWidth words of DataWidth bits, two independent ports,
// per-byte write enables, selectable same-port write mode, 1- or 2-cycle read
// latency with valid strobe, cross-port collision resolution (port A wins on
// shared bytes, a reading port sees the old word) and an optional zeroing sweep
// after reset.
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   addra_i/ena_i/wea_i/dina_i     port A address, enable, byte write enables, write data
//   addrb_i/enb_i/web_i/dinb_i     port B address, enable, byte write enables, write data
//   douta_o/valida_o               port A result word and valid strobe
//   doutb_o/validb_o               port B result word and valid strobe
//   busy_o                         clear sweep in progress, user accesses ignored
//   collision_o                    one-cycle pulse after a same-address access with a write

module bram_tdp
    import bram_pkg::*;
#(
    parameter int          DataWidth    = 16,
    parameter int          AddrWidth    = 9,
    parameter int          ByteWidth    = 8,
    parameter int          ReadLatency  = 1,
    parameter write_mode_e WriteMode    = WM_READ_FIRST,
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [AddrWidth-1:0]           addra_i,
    input  logic                           ena_i,
    input  logic [DataWidth/ByteWidth-1:0] wea_i,
    input  logic [DataWidth-1:0]           dina_i,
    output logic [DataWidth-1:0]           douta_o,
    output logic                           valida_o,
    input  logic [AddrWidth-1:0]           addrb_i,
    input  logic                           enb_i,
    input  logic [DataWidth/ByteWidth-1:0] web_i,
    input  logic [DataWidth-1:0]           dinb_i,
    output logic [DataWidth-1:0]           doutb_o,
    output logic                           validb_o,
    output logic                           busy_o,
    output logic                           collision_o
);

    localparam int Depth    = 2 ** AddrWidth;
    localparam int NumBytes = DataWidth / ByteWidth;

    if ((ReadLatency != 1) && (ReadLatency != 2)) begin : g_bad_latency
        $error("bram_tdp: ReadLatency must be 1 or 2");
    end
    if (!byte_merge_ok(DataWidth, ByteWidth)) begin : g_bad_bytes
        $error("bram_tdp: DataWidth must be a multiple of ByteWidth");
    end

    logic [DataWidth-1:0] r_mem [Depth];

    states_e              r_state;
    states_e              w_state_nxt;
    logic [AddrWidth-1:0] r_clr_cnt;
    logic                 r_collision;

    logic                 w_ready;
    logic                 w_acc_a;
    logic                 w_acc_b;
    logic                 w_wr_a;
    logic                 w_wr_b;
    logic                 w_collision;
    logic [DataWidth-1:0] w_old_a;
    logic [DataWidth-1:0] w_old_b;
    logic [DataWidth-1:0] w_merge_a;
    logic [DataWidth-1:0] w_merge_b;
    logic [DataWidth-1:0] w_res_a;
    logic [DataWidth-1:0] w_res_b;
    logic                 w_vld_a;
    logic                 w_vld_b;

    // User accesses only count once the sweep has finished.
    assign w_ready = (r_state == READY);
    assign w_acc_a = ena_i & w_ready;
    assign w_acc_b = enb_i & w_ready;
    assign w_wr_a  = w_acc_a & (|wea_i);
    assign w_wr_b  = w_acc_b & (|web_i);

    assign w_collision = w_acc_a & w_acc_b & (addra_i == addrb_i) & (w_wr_a | w_wr_b);

    // Both ports read the pre-edge contents, so a reading port in a collision
    // naturally sees the old word.
    assign w_old_a = r_mem[addra_i];
    assign w_old_b = r_mem[addrb_i];

    always_comb begin
        w_merge_a = w_old_a;
        w_merge_b = w_old_b;
        for (int i = 0; i < NumBytes; i++) begin
            if (wea_i[i]) begin
                w_merge_a[i*ByteWidth +: ByteWidth] = dina_i[i*ByteWidth +: ByteWidth];
            end
            if (web_i[i]) begin
                w_merge_b[i*ByteWidth +: ByteWidth] = dinb_i[i*ByteWidth +: ByteWidth];
            end
        end
    end

    always_comb begin
        w_res_a = w_old_a;
        w_vld_a = 1'b0;
        if (w_acc_a) begin
            if (!w_wr_a) begin
                w_vld_a = 1'b1;
            end else begin
                case (WriteMode)
                    WM_READ_FIRST:  w_vld_a = 1'b1;
                    WM_WRITE_FIRST: begin
                        w_res_a = w_merge_a;
                        w_vld_a = 1'b1;
                    end
                    default:        w_vld_a = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        w_res_b = w_old_b;
        w_vld_b = 1'b0;
        if (w_acc_b) begin
            if (!w_wr_b) begin
                w_vld_b = 1'b1;
            end else begin
                case (WriteMode)
                    WM_READ_FIRST:  w_vld_b = 1'b1;
                    WM_WRITE_FIRST: begin
                        w_res_b = w_merge_b;
                        w_vld_b = 1'b1;
                    end
                    default:        w_vld_b = 1'b0;
                endcase
            end
        end
    end

    // Port B lanes are written first so that port A's later assignment wins on
    // any lane both ports enable at the same address.
    always_ff @(posedge clk_i) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NumBytes; i++) begin
                if (w_wr_b && web_i[i]) begin
                    r_mem[addrb_i][i*ByteWidth +: ByteWidth] <= dinb_i[i*ByteWidth +: ByteWidth];
                end
            end
            for (int i = 0; i < NumBytes; i++) begin
                if (w_wr_a && wea_i[i]) begin
                    r_mem[addra_i][i*ByteWidth +: ByteWidth] <= dina_i[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ClearOnReset ? CLEAR : READY;
            r_clr_cnt   <= '0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= (r_state == CLEAR) ? r_clr_cnt + 1'b1 : '0;
            r_collision <= w_collision;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (&r_clr_cnt) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = READY;
        endcase
    end

    assign busy_o      = (r_state == CLEAR);
    assign collision_o = r_collision;

    bram_port_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_pipe_a (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_valid (w_vld_a),
        .i_data  (w_res_a),
        .o_data  (douta_o),
        .o_valid (valida_o)
    );

    bram_port_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_pipe_b (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_valid (w_vld_b),
        .i_data  (w_res_b),
        .o_data  (doutb_o),
        .o_valid (validb_o)
    );

endmodule

// File: tb/tb_bram_tdp.sv
// tb/tb_bram_tdp.sv - self-checking bench for bram_tdp across write modes and latencies

module tb_bram_tdp;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  addra, addrb;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic [15:0] dina, dinb;

    // Instances: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE (latency 1), 3 READ_FIRST latency 2
    logic [15:0] da [4];
    logic [15:0] db [4];
    logic        va [4];
    logic        vb [4];
    logic        busy [4];
    logic        col [4];

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model
    logic [15:0] m_mem [16];
    logic [15:0] e_da [3];
    logic [15:0] e_db [3];
    logic        e_va [3];
    logic        e_vb [3];
    logic [15:0] e2_da, e2_db;
    logic        e2_va, e2_vb;
    logic        e_col;

    always #5 clk = ~clk;

    bram_tdp #(.DataWidth(16), .AddrWidth(4), .ByteWidth(8), .ReadLatency(1),
               .WriteMode(WM_READ_FIRST), .ClearOnReset(1'b1)) u_rf (
        .clk_i(clk), .rstn_i(rstn),
        .addra_i(addra), .ena_i(ena), .wea_i(wea), .dina_i(dina), .douta_o(da[0]), .valida_o(va[0]),
        .addrb_i(addrb), .enb_i(enb), .web_i(web), .dinb_i(dinb), .doutb_o(db[0]), .validb_o(vb[0]),
        .busy_o(busy[0]), .collision_o(col[0]));

    bram_tdp #(.DataWidth(16), .AddrWidth(4), .ByteWidth(8), .ReadLatency(1),
               .WriteMode(WM_WRITE_FIRST), .ClearOnReset(1'b1)) u_wf (
        .clk_i(clk), .rstn_i(rstn),
        .addra_i(addra), .ena_i(ena), .wea_i(wea), .dina_i(dina), .douta_o(da[1]), .valida_o(va[1]),
        .addrb_i(addrb), .enb_i(enb), .web_i(web), .dinb_i(dinb), .doutb_o(db[1]), .validb_o(vb[1]),
        .busy_o(busy[1]), .collision_o(col[1]));

    bram_tdp #(.DataWidth(16), .AddrWidth(4), .ByteWidth(8), .ReadLatency(1),
               .WriteMode(WM_NO_CHANGE), .ClearOnReset(1'b1)) u_nc (
        .clk_i(clk), .rstn_i(rstn),
        .addra_i(addra), .ena_i(ena), .wea_i(wea), .dina_i(dina), .douta_o(da[2]), .valida_o(va[2]),
        .addrb_i(addrb), .enb_i(enb), .web_i(web), .dinb_i(dinb), .doutb_o(db[2]), .validb_o(vb[2]),
        .busy_o(busy[2]), .collision_o(col[2]));

    bram_tdp #(.DataWidth(16), .AddrWidth(4), .ByteWidth(8), .ReadLatency(2),
               .WriteMode(WM_READ_FIRST), .ClearOnReset(1'b1)) u_l2 (
        .clk_i(clk), .rstn_i(rstn),
        .addra_i(addra), .ena_i(ena), .wea_i(wea), .dina_i(dina), .douta_o(da[3]), .valida_o(va[3]),
        .addrb_i(addrb), .enb_i(enb), .web_i(web), .dinb_i(dinb), .doutb_o(db[3]), .validb_o(vb[3]),
        .busy_o(busy[3]), .collision_o(col[3]));

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                          input logic [1:0] we);
        logic [15:0] r;
        r = old;
        if (we[0]) r[7:0]  = din[7:0];
        if (we[1]) r[15:8] = din[15:8];
        return r;
    endfunction

    // {valid, data} seen on a latency-1 port after one access, for a given write mode
    function automatic logic [16:0] port_result(input logic en, input logic [1:0] we,
                                                input logic [15:0] old, input logic [15:0] din,
                                                input logic [15:0] hold, input int mode);
        if (!en)       return {1'b0, hold};
        if (we == 2'b00) return {1'b1, old};
        if (mode == 0) return {1'b1, old};
        if (mode == 1) return {1'b1, merge(old, din, we)};
        return {1'b0, hold};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            e_da[k] = 16'h0; e_db[k] = 16'h0; e_va[k] = 1'b0; e_vb[k] = 1'b0;
        end
        e2_da = 16'h0; e2_db = 16'h0; e2_va = 1'b0; e2_vb = 1'b0; e_col = 1'b0;
    endtask

    task automatic set_a(input logic en, input logic [1:0] we, input logic [3:0] ad, input logic [15:0] d);
        ena = en; wea = we; addra = ad; dina = d;
    endtask

    task automatic set_b(input logic en, input logic [1:0] we, input logic [3:0] ad, input logic [15:0] d);
        enb = en; web = we; addrb = ad; dinb = d;
    endtask

    // One clock edge with the current inputs; the model advances to what the
    // outputs must show just after that edge.
    task automatic tick();
        logic [16:0] ra [3];
        logic [16:0] rb [3];
        logic [15:0] oa, ob, p_da, p_db;
        logic        p_va, p_vb, ncol;
        oa = m_mem[addra];
        ob = m_mem[addrb];
        ncol = ena && enb && (addra == addrb) && ((wea != 2'b00) || (web != 2'b00));
        for (int k = 0; k < 3; k++) begin
            ra[k] = port_result(ena, wea, oa, dina, e_da[k], k);
            rb[k] = port_result(enb, web, ob, dinb, e_db[k], k);
        end
        p_da = e_da[0]; p_db = e_db[0]; p_va = e_va[0]; p_vb = e_vb[0];
        if (enb && web != 2'b00) m_mem[addrb] = merge(m_mem[addrb], dinb, web);
        if (ena && wea != 2'b00) m_mem[addra] = merge(m_mem[addra], dina, wea);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e_va[k] = ra[k][16]; e_da[k] = ra[k][15:0];
            e_vb[k] = rb[k][16]; e_db[k] = rb[k][15:0];
        end
        // A second register stage shows the latency-1 picture one cycle later.
        e2_da = p_da; e2_db = p_db; e2_va = p_va; e2_vb = p_vb;
        e_col = ncol;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({da[k], db[k], va[k], vb[k], col[k], busy[k]} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got da=%h db=%h va=%b vb=%b col=%b busy=%b, expected 0 0 0 0 0 1",
                         k, da[k], db[k], va[k], vb[k], col[k], busy[k]);
            end
        end
    endtask

    // Counts edges from reset release until busy_o drops; user traffic during the
    // sweep must be ignored.
    task automatic sweep_and_count(output int cnt);
        cnt = 0;
        set_a(1'b1, 2'b11, 4'h5, 16'hFFFF);
        set_b(1'b1, 2'b11, 4'h5, 16'hEEEE);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            n_cmp++;
            if (va[0] !== 1'b0 || vb[0] !== 1'b0 || col[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_ignores_access: got va=%b vb=%b col=%b, expected 0 0 0", va[0], vb[0], col[0]);
            end
            if (busy[0] === 1'b0) break;
        end
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
    endtask

    task automatic test_clear();
        int cnt;
        rstn = 1'b1;
        sweep_and_count(cnt);
        n_cmp++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL clear_duration: got %0d cycles, expected 16", cnt);
        end
        model_reset();
        set_a(1'b1, 2'b00, 4'h5, 16'h0);
        tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        n_cmp++;
        if (da[0] !== 16'h0000 || va[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_read5: got %h/%b, expected 0000/1", da[0], va[0]);
        end
    endtask

    task automatic test_byte_enables();
        set_a(1'b1, 2'b11, 4'h3, 16'hABCD); tick();
        set_a(1'b1, 2'b01, 4'h3, 16'h0012); tick();
        set_a(1'b1, 2'b00, 4'h3, 16'h0000); tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (da[k] !== 16'hAB12 || va[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL byte_enable inst%0d: got %h/%b, expected ab12/1", k, da[k], va[k]);
            end
        end
    endtask

    task automatic test_write_mode();
        set_a(1'b1, 2'b11, 4'h7, 16'h1111); tick();
        set_a(1'b1, 2'b11, 4'h7, 16'h2222); tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0000);
        n_cmp++;
        if (da[0] !== 16'h1111 || va[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_read_first: got %h/%b, expected 1111/1", da[0], va[0]);
        end
        n_cmp++;
        if (da[1] !== 16'h2222 || va[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_write_first: got %h/%b, expected 2222/1", da[1], va[1]);
        end
        n_cmp++;
        if (da[2] !== 16'hAB12 || va[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_no_change: got %h/%b, expected ab12/0", da[2], va[2]);
        end
    endtask

    task automatic test_collision();
        set_a(1'b1, 2'b01, 4'h9, 16'h00FF);
        set_b(1'b1, 2'b11, 4'h9, 16'h3344);
        tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
        n_cmp++;
        if (col[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_pulse: got %b, expected 1", col[0]);
        end
        tick();
        n_cmp++;
        if (col[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_one_cycle: got %b, expected 0", col[0]);
        end
        set_a(1'b1, 2'b00, 4'h9, 16'h0);
        tick();
        n_cmp++;
        if (da[0] !== 16'h33FF) begin
            n_fail++;
            $display("FAIL collision_merge: got %h, expected 33ff", da[0]);
        end
        set_a(1'b1, 2'b11, 4'h9, 16'h5555);
        set_b(1'b1, 2'b00, 4'h9, 16'h0);
        tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (db[k] !== 16'h33FF || vb[k] !== 1'b1 || col[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL collision_read_old inst%0d: got %h/%b col=%b, expected 33ff/1 col=1",
                         k, db[k], vb[k], col[k]);
            end
        end
        tick();
    endtask

    task automatic test_latency2();
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 2'b11, 4'(i), 16'h1000 + 16'(i));
            tick();
        end
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_a(1'b1, 2'b00, 4'(i), 16'h0);
            else       set_a(1'b0, 2'b00, 4'h0, 16'h0);
            tick();
            n_cmp++;
            if (i >= 1 && i <= 4) begin
                if (da[3] !== (16'h1000 + 16'(i - 1)) || va[3] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency2_read%0d: got %h/%b, expected %h/1", i - 1, da[3], va[3],
                             16'h1000 + 16'(i - 1));
                end
            end else if (va[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL latency2_idle%0d: got valid %b, expected 0", i, va[3]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                  16'($urandom));
            set_b($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                  16'($urandom));
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (da[k] !== e_da[k] || va[k] !== e_va[k] || db[k] !== e_db[k] || vb[k] !== e_vb[k]) begin
                    n_fail++;
                    $display("FAIL random_lat1 step%0d inst%0d: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b",
                             n, k, da[k], va[k], db[k], vb[k], e_da[k], e_va[k], e_db[k], e_vb[k]);
                end
            end
            n_cmp++;
            if (da[3] !== e2_da || va[3] !== e2_va || db[3] !== e2_db || vb[3] !== e2_vb) begin
                n_fail++;
                $display("FAIL random_lat2 step%0d: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b",
                         n, da[3], va[3], db[3], vb[3], e2_da, e2_va, e2_db, e2_vb);
            end
            n_cmp++;
            if (col[0] !== e_col) begin
                n_fail++;
                $display("FAIL random_collision step%0d: got %b, expected %b", n, col[0], e_col);
            end
        end
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
    endtask

    task automatic test_mid_clear_reset();
        int cnt;
        set_a(1'b1, 2'b11, 4'h2, 16'hBEEF); tick();
        set_a(1'b1, 2'b00, 4'h2, 16'h0);
        set_b(1'b1, 2'b00, 4'h2, 16'h0);
        tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
        rstn = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({da[k], db[k], va[k], vb[k], col[k], busy[k]} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: got da=%h db=%h va=%b vb=%b col=%b busy=%b, expected 0 0 0 0 0 1",
                         k, da[k], db[k], va[k], vb[k], col[k], busy[k]);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b, expected 1", busy[0]);
        end
        rstn = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sweep_and_count(cnt);
        n_cmp++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL midclear_restart: got %0d cycles, expected 16", cnt);
        end
        model_reset();
        set_a(1'b1, 2'b00, 4'h2, 16'h0);
        set_b(1'b1, 2'b00, 4'h9, 16'h0);
        tick();
        set_a(1'b0, 2'b00, 4'h0, 16'h0);
        set_b(1'b0, 2'b00, 4'h0, 16'h0);
        n_cmp++;
        if (da[0] !== 16'h0000 || va[0] !== 1'b1 || db[0] !== 16'h0000 || vb[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_zeroed: got a=%h/%b b=%h/%b, expected 0000/1 0000/1", da[0], va[0], db[0], vb[0]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear();
        test_byte_enables();
        test_write_mode();
        test_collision();
        test_latency2();
        test_random();
        test_mid_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
